// File: rtl/data_mem_if.sv
// data_mem_intf: load/store bus bundle between the memory stage and the data memory
interface data_mem_intf;
  logic [3:0]  wr_sel;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output wr_sel, addr, wr_data, input rd_data);
  modport slave (input wr_sel, addr, wr_data, output rd_data);
  modport monitor (input wr_sel, addr, wr_data, rd_data);
endinterface

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with byte write selects and combinational read
module data_mem #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_intf.slave  bus
);
  logic [31:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          wr_word_d;
  logic                 unused_addr;
  assign idx         = bus.addr[ADDR_BITS-1:0];
  assign unused_addr = ^bus.addr[31:ADDR_BITS];
  assign bus.rd_data = mem_q[idx];
  // Merge enabled write lanes over the current word; disabled lanes keep old bytes
  always_comb begin
    wr_word_d = mem_q[idx];
    for (int i = 0; i < 4; i++)
      wr_word_d[8*i+:8] = bus.wr_sel[i] ? bus.wr_data[8*i+:8] : mem_q[idx][8*i+:8];
  end
  // Reset clears every word; otherwise commit the merged word when any lane is enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++)
        mem_q[w] <= '0;
    end else if (|bus.wr_sel) begin
      mem_q[idx] <= wr_word_d;
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: table-driven and random scoreboard checks of data_mem
module tb_data_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_intf bus();
  data_mem #(.DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rd_addr;
    logic [31:0] pre;
    logic [31:0] post;
  } vec_t;
  vec_t        v [8];
  logic [31:0] exp_q [$];
  logic [31:0] model [256];
  logic [31:0] ra [3];
  int          checks = 0;
  int          errors = 0;
  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask
  task automatic drive(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    bus.wr_sel  = s;
    bus.addr    = a;
    bus.wr_data = d;
  endtask
  task automatic read_zero(input string name, input logic [31:0] a);
    drive(4'h0, a, 32'h0);
    #1;
    exp_q.push_back(32'h0);
    check(name, bus.rd_data);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0]  s;
    logic [31:0] a, d;
    v[0] = '{4'hF, 32'd10,  32'hDEADBEEF, 32'd10, 32'h0,        32'hDEADBEEF};
    v[1] = '{4'hF, 32'd3,   32'h11223344, 32'd3,  32'h0,        32'h11223344};
    v[2] = '{4'h2, 32'd3,   32'hAABBCCDD, 32'd3,  32'h11223344, 32'h1122CC44};
    v[3] = '{4'hC, 32'd3,   32'h55667788, 32'd3,  32'h1122CC44, 32'h5566CC44};
    v[4] = '{4'h0, 32'd3,   32'hFFFFFFFF, 32'd3,  32'h5566CC44, 32'h5566CC44};
    v[5] = '{4'hF, 32'd263, 32'hCAFEF00D, 32'd7,  32'h0,        32'hCAFEF00D};
    v[6] = '{4'h1, 32'd7,   32'h000000AA, 32'd7,  32'hCAFEF00D, 32'hCAFEF0AA};
    v[7] = '{4'hF, 32'h100, 32'h12345678, 32'd0,  32'h0,        32'h12345678};
    ra = '{32'd0, 32'd5, 32'd255};
    drive(4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(4'hF, 32'd5, 32'h00001234);
    #3;
    exp_q.push_back(32'h0);
    check("rst_hold_rd", bus.rd_data);
    @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    check("rst_blocks_wr", bus.rd_data);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) read_zero($sformatf("reset_clear_%0d", i), ra[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(v[i].sel, v[i].addr, v[i].data);
      exp_q.push_back(v[i].pre);
      #3;
      check($sformatf("vec%0d_pre", i), bus.rd_data);
      @(posedge clk);
      #1;
      drive(4'h0, v[i].rd_addr, 32'h0);
      #1;
      exp_q.push_back(v[i].post);
      check($sformatf("vec%0d_post", i), bus.rd_data);
    end
    @(negedge clk);
    drive(4'h0, 32'd10, 32'h0);
    #1;
    exp_q.push_back(32'hDEADBEEF);
    check("pre_async_rst", bus.rd_data);
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    check("async_rst", bus.rd_data);
    @(negedge clk);
    rst = 1'b0;
    read_zero("post_rst_3", 32'd3);
    read_zero("post_rst_7", 32'd7);
    read_zero("post_rst_0", 32'd0);
    for (int w = 0; w < 256; w++) model[w] = 32'h0;
    repeat (1000) begin
      @(negedge clk);
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      d = $urandom;
      drive(s, a, d);
      exp_q.push_back(model[a[7:0]]);
      #3;
      check("rand", bus.rd_data);
      @(posedge clk);
      for (int l = 0; l < 4; l++)
        if (s[l]) model[a[7:0]][8*l+:8] = d[8*l+:8];
    end
    @(negedge clk);
    drive(4'h0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
